// File: rtl/pc_redirect_unit.sv
// Program counter owner with EX-stage redirect, pipeline flush and pending-redirect hold.
// Optional feature: define MISALIGN_TRAP_EN to trap misaligned targets to TRAP_VECTOR.
module pc_redirect_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR = 32'h0000_0100
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        stall,
    input  logic        imem_busy,
    input  logic        isJumpOrBranch,
    input  logic [31:0] branch_target,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        flush_if_id,
    output logic        flush_id_ex,
    output logic        fetch_valid,
    output logic        redirect_pending,
    output logic        misaligned_trap
);

    typedef enum logic {
        RUN     = 1'b0,
        PENDING = 1'b1
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [31:0] r_pc, w_pc_nxt;
    logic [31:0] r_target, w_target_nxt;
    logic [31:0] w_eff_target;
    logic        w_take;

    assign w_take = isJumpOrBranch;

`ifdef MISALIGN_TRAP_EN
    logic w_misaligned;
    assign w_misaligned    = |branch_target[1:0];
    assign w_eff_target    = w_misaligned ? TRAP_VECTOR : {branch_target[31:2], 2'b00};
    assign misaligned_trap = w_take & w_misaligned;
`else
    logic w_unused;
    assign w_unused        = ^{branch_target[1:0], TRAP_VECTOR};
    assign w_eff_target    = {branch_target[31:2], 2'b00};
    assign misaligned_trap = 1'b0;
`endif

    // A redirect always wins over stall: the EX instruction is older than the stalled one.
    always_comb begin
        w_state_nxt  = r_state;
        w_pc_nxt     = r_pc;
        w_target_nxt = r_target;
        if (w_take) begin
            w_target_nxt = w_eff_target;
            if (imem_busy) begin
                w_state_nxt = PENDING;
            end else begin
                w_pc_nxt    = w_eff_target;
                w_state_nxt = RUN;
            end
        end else if (r_state == PENDING) begin
            if (!imem_busy) begin
                w_pc_nxt    = r_target;
                w_state_nxt = RUN;
            end
        end else if (!stall && !imem_busy) begin
            w_pc_nxt = r_pc + 32'd4;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state  <= RUN;
            r_pc     <= RESET_PC;
            r_target <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_pc     <= w_pc_nxt;
            r_target <= w_target_nxt;
        end
    end

    assign pc               = r_pc;
    assign pc_plus4         = r_pc + 32'd4;
    assign flush_if_id      = w_take;
    assign flush_id_ex      = w_take;
    assign redirect_pending = (r_state == PENDING);
    assign fetch_valid      = (r_state != PENDING);

endmodule
